// File: rtl/sram_ctrlr_v2_if.sv
// Request/response bundle between the A/B SRAM arbiter and one SRAM controller.
// The arbiter side is the master; the controller side is the slave.
interface sram_ctrlr_v2_if #(
  parameter int ADR_W = 20,
  parameter int DAT_W = 16
);
  logic             i_mem;
  logic             i_rw;
  logic [DAT_W-1:0] i_din;
  logic [ADR_W-1:0] i_adr;
  logic             o_ready;
  logic [DAT_W-1:0] o_dout;

  modport master (
    output i_mem,
    output i_rw,
    output i_din,
    output i_adr,
    input  o_ready,
    input  o_dout
  );

  modport slave (
    input  i_mem,
    input  i_rw,
    input  i_din,
    input  i_adr,
    output o_ready,
    output o_dout
  );
endinterface

// File: rtl/sram_ctrlr_v2.sv
// Single-port controller for one external asynchronous 16-bit SRAM.
// A level request is latched when the controller is idle and turned into a
// fully registered pin sequence: every SRAM pin, o_ready and o_dout are flops.
module sram_ctrlr_v2 #(
  parameter int ADR_W     = 20,
  parameter int DAT_W     = 16,
  parameter int RD_CYCLES = 2,
  parameter int WR_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  sram_ctrlr_v2_if.slave   bus,
  output logic [ADR_W-1:0] sram_adr,
  inout  wire  [DAT_W-1:0] sram_dq,
  output logic             sram_ce_n,
  output logic             sram_oe_n,
  output logic             sram_we_n,
  output logic             sram_lb_n,
  output logic             sram_ub_n
);

  localparam int MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYCLES - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD      = 2'd1;
  localparam logic [1:0] ST_WR      = 2'd2;
  localparam logic [1:0] ST_WR_HOLD = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             dq_oe;
  logic [DAT_W-1:0] din_q;

  // The data bus is only driven while a write (including its hold cycle) is in flight.
  assign sram_dq = dq_oe ? din_q : {DAT_W{1'bz}};

  // Write data is captured on accept; it has no meaning outside an access, so no reset.
  always_ff @(posedge clk) begin
    if (bus.o_ready && bus.i_mem && (state == ST_IDLE)) begin
      din_q <= bus.i_din;
    end
  end

  // Access sequencer: accept in IDLE, then step the read or write pin sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      dq_oe       <= 1'b0;
      bus.o_ready <= 1'b1;
      bus.o_dout  <= '0;
      sram_adr    <= '0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      sram_lb_n   <= 1'b1;
      sram_ub_n   <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.i_mem) begin
            cnt         <= '0;
            sram_adr    <= bus.i_adr;
            sram_ce_n   <= 1'b0;
            sram_lb_n   <= 1'b0;
            sram_ub_n   <= 1'b0;
            bus.o_ready <= 1'b0;
            if (bus.i_rw) begin
              // Read: enable SRAM outputs, keep our driver off the bus.
              sram_oe_n <= 1'b0;
              state     <= ST_RD;
            end else begin
              // Write: drive data and strobe WE_n from the same edge.
              sram_we_n <= 1'b0;
              dq_oe     <= 1'b1;
              state     <= ST_WR;
            end
          end
        end

        ST_RD: begin
          cnt <= cnt + 1'b1;
          if (cnt == RD_LAST) begin
            bus.o_dout  <= sram_dq;
            sram_oe_n   <= 1'b1;
            sram_ce_n   <= 1'b1;
            sram_lb_n   <= 1'b1;
            sram_ub_n   <= 1'b1;
            bus.o_ready <= 1'b1;
            state       <= ST_IDLE;
          end
        end

        ST_WR: begin
          cnt <= cnt + 1'b1;
          if (cnt == WR_LAST) begin
            // Release WE_n first; data and address stay one more clock for hold time.
            sram_we_n <= 1'b1;
            state     <= ST_WR_HOLD;
          end
        end

        ST_WR_HOLD: begin
          dq_oe       <= 1'b0;
          sram_ce_n   <= 1'b1;
          sram_lb_n   <= 1'b1;
          sram_ub_n   <= 1'b1;
          bus.o_ready <= 1'b1;
          state       <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrlr_v2.sv
// Bench for sram_ctrlr_v2: one default instance (2/2 cycles) and one 1/1 build,
// each with a small behavioural async SRAM model on a pulled-up data bus.
module tb_sram_ctrlr_v2;

  logic clk;
  logic rst;

  int total = 0;
  int bad   = 0;

  logic [15:0] sb[$];

  sram_ctrlr_v2_if #(.ADR_W(20), .DAT_W(16)) bus_a ();
  sram_ctrlr_v2_if #(.ADR_W(20), .DAT_W(16)) bus_b ();

  logic [19:0] adr_a, adr_b;
  logic        ce_n_a, oe_n_a, we_n_a, lb_n_a, ub_n_a;
  logic        ce_n_b, oe_n_b, we_n_b, lb_n_b, ub_n_b;
  tri1  [15:0] dq_a;
  tri1  [15:0] dq_b;

  logic [15:0] mem_a [16] = '{default: 16'h0000};
  logic [15:0] mem_b [16] = '{default: 16'h0000};

  sram_ctrlr_v2 #(.ADR_W(20), .DAT_W(16), .RD_CYCLES(2), .WR_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a),
    .sram_adr(adr_a), .sram_dq(dq_a), .sram_ce_n(ce_n_a), .sram_oe_n(oe_n_a),
    .sram_we_n(we_n_a), .sram_lb_n(lb_n_a), .sram_ub_n(ub_n_a)
  );

  sram_ctrlr_v2 #(.ADR_W(20), .DAT_W(16), .RD_CYCLES(1), .WR_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b),
    .sram_adr(adr_b), .sram_dq(dq_b), .sram_ce_n(ce_n_b), .sram_oe_n(oe_n_b),
    .sram_we_n(we_n_b), .sram_lb_n(lb_n_b), .sram_ub_n(ub_n_b)
  );

  // SRAM models: drive data while selected with OE_n low, store on WE_n rising.
  assign dq_a = (!ce_n_a && !oe_n_a) ? mem_a[adr_a[3:0]] : 16'hzzzz;
  assign dq_b = (!ce_n_b && !oe_n_b) ? mem_b[adr_b[3:0]] : 16'hzzzz;

  always @(posedge we_n_a) if (!rst && !ce_n_a) mem_a[adr_a[3:0]] = dq_a;
  always @(posedge we_n_b) if (!rst && !ce_n_b) mem_b[adr_b[3:0]] = dq_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pin protocol monitor: strobes exclusive, and while OE_n is low only the SRAM drives.
  always @(negedge clk) begin
    if (!rst) begin
      check("a_oe_we_excl", {31'd0, (!oe_n_a && !we_n_a)}, 32'd0);
      check("b_oe_we_excl", {31'd0, (!oe_n_b && !we_n_b)}, 32'd0);
      if (!oe_n_a) check("a_dq_rd_only", {16'd0, dq_a}, {16'd0, mem_a[adr_a[3:0]]});
      if (!oe_n_b) check("b_dq_rd_only", {16'd0, dq_b}, {16'd0, mem_b[adr_b[3:0]]});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit b, input bit m, input bit rw,
                       input logic [19:0] a, input logic [15:0] d);
    if (b) begin
      bus_b.i_mem = m; bus_b.i_rw = rw; bus_b.i_adr = a; bus_b.i_din = d;
    end else begin
      bus_a.i_mem = m; bus_a.i_rw = rw; bus_a.i_adr = a; bus_a.i_din = d;
    end
  endtask

  function automatic logic rdy(input bit b);
    return b ? bus_b.o_ready : bus_a.o_ready;
  endfunction

  function automatic logic [15:0] dout(input bit b);
    return b ? bus_b.o_dout : bus_a.o_dout;
  endfunction

  // Ticks until o_ready is high, counting samples spent low; bounded.
  task automatic wait_rdy(input bit b, output int lo);
    lo = 0;
    for (int i = 0; i < 20; i++) begin
      if (rdy(b)) break;
      lo++;
      tick();
    end
    check(b ? "b_ready_timeout" : "a_ready_timeout", {31'd0, rdy(b)}, 32'd1);
  endtask

  // One complete access: present for one accept edge, then drop (optionally scramble) inputs.
  task automatic access(input bit b, input bit rw, input logic [19:0] a, input logic [15:0] d,
                        input bit chg, output int lo, output int we_lo, output int oe_lo,
                        output int dqv);
    lo = 0; we_lo = 0; oe_lo = 0; dqv = 0;
    drive(b, 1'b1, rw, a, d);
    tick();
    if (chg) drive(b, 1'b0, ~rw, ~a, ~d);
    else     drive(b, 1'b0, rw, a, d);
    for (int i = 0; i < 20; i++) begin
      if (rdy(b)) break;
      lo++;
      if (!(b ? we_n_b : we_n_a)) we_lo++;
      if (!(b ? oe_n_b : oe_n_a)) oe_lo++;
      if ((b ? dq_b : dq_a) === d) dqv++;
      tick();
    end
    check(b ? "b_access_timeout" : "a_access_timeout", {31'd0, rdy(b)}, 32'd1);
  endtask

  task automatic do_read(input bit b, input logic [19:0] a, input logic [15:0] exp,
                         input bit chg, input int lat, input string tag);
    int lo, we_lo, oe_lo, dqv;
    logic [15:0] want;
    sb.push_back(exp);
    access(b, 1'b1, a, 16'h0000, chg, lo, we_lo, oe_lo, dqv);
    check({tag, "_ready_lo"}, lo, lat);
    check({tag, "_oe_lo"}, oe_lo, lat);
    check({tag, "_we_lo"}, we_lo, 0);
    want = sb.pop_front();
    check({tag, "_dout"}, {16'd0, dout(b)}, {16'd0, want});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int lo, we_lo, oe_lo, dqv;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 20'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 20'h0, 16'h0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // Reset values
    tick();
    check("rst_ready", {31'd0, bus_a.o_ready}, 32'd1);
    check("rst_dout", {16'd0, bus_a.o_dout}, 32'd0);
    check("rst_adr", {12'd0, adr_a}, 32'd0);
    check("rst_pins", {27'd0, ce_n_a, oe_n_a, we_n_a, lb_n_a, ub_n_a}, 32'h1f);
    check("rst_dq_z", {16'd0, dq_a}, 32'h0000ffff);

    // Asynchronous reset in the middle of a clock during a write
    drive(1'b0, 1'b1, 1'b0, 20'h00009, 16'h7777);
    tick();
    drive(1'b0, 1'b0, 1'b0, 20'h00009, 16'h7777);
    check("mid_we_low", {31'd0, we_n_a}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("async_ready", {31'd0, bus_a.o_ready}, 32'd1);
    check("async_pins", {27'd0, ce_n_a, oe_n_a, we_n_a, lb_n_a, ub_n_a}, 32'h1f);
    check("async_dq_z", {16'd0, dq_a}, 32'h0000ffff);
    check("async_adr", {12'd0, adr_a}, 32'd0);
    #1 rst = 1'b0;
    tick();
    check("async_no_write", {16'd0, mem_a[9]}, 32'd0);

    // Default write
    access(1'b0, 1'b0, 20'h00005, 16'hA5C3, 1'b0, lo, we_lo, oe_lo, dqv);
    check("wr_ready_lo", lo, 3);
    check("wr_we_lo", we_lo, 2);
    check("wr_oe_lo", oe_lo, 0);
    check("wr_dq_cycles", dqv, 3);
    check("wr_stored", {16'd0, mem_a[5]}, 32'h0000a5c3);
    check("wr_dq_released", {16'd0, dq_a}, 32'h0000ffff);
    check("wr_dout_kept", {16'd0, bus_a.o_dout}, 32'd0);

    // Default read
    do_read(1'b0, 20'h00005, 16'hA5C3, 1'b0, 2, "rd");
    check("rd_pins_idle", {27'd0, ce_n_a, oe_n_a, we_n_a, lb_n_a, ub_n_a}, 32'h1f);

    // i_mem held high: write, read, write to the top address
    drive(1'b0, 1'b1, 1'b0, 20'hFFFFF, 16'h1234);
    tick();
    check("b2b_w1_we", {31'd0, we_n_a}, 32'd0);
    check("b2b_w1_lanes", {30'd0, lb_n_a, ub_n_a}, 32'd0);
    bus_a.i_rw = 1'b1;
    wait_rdy(1'b0, lo);
    check("b2b_w1_lo", lo, 3);
    sb.push_back(16'h1234);
    tick();
    check("b2b_gap_ready", {31'd0, bus_a.o_ready}, 32'd0);
    check("b2b_r1_oe", {31'd0, oe_n_a}, 32'd0);
    wait_rdy(1'b0, lo);
    check("b2b_r1_lo", lo, 2);
    check("b2b_r1_dout", {16'd0, bus_a.o_dout}, {16'd0, sb.pop_front()});
    bus_a.i_rw  = 1'b0;
    bus_a.i_din = 16'hBEEF;
    tick();
    check("b2b_w2_we", {31'd0, we_n_a}, 32'd0);
    bus_a.i_mem = 1'b0;
    wait_rdy(1'b0, lo);
    check("b2b_w2_lo", lo, 3);
    tick();
    check("b2b_no_repeat", {31'd0, bus_a.o_ready}, 32'd1);
    do_read(1'b0, 20'hFFFFF, 16'hBEEF, 1'b0, 2, "b2b_rd");

    // Reset after one of two read cycles
    drive(1'b0, 1'b1, 1'b1, 20'h00005, 16'h0000);
    tick();
    bus_a.i_mem = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    check("rdrst_dout", {16'd0, bus_a.o_dout}, 32'd0);
    check("rdrst_oe", {31'd0, oe_n_a}, 32'd1);
    check("rdrst_ready", {31'd0, bus_a.o_ready}, 32'd1);
    #1 rst = 1'b0;
    tick();
    do_read(1'b0, 20'h00005, 16'hA5C3, 1'b0, 2, "rdrst_rd");

    // 1/1 build with inputs scrambled right after accept
    access(1'b1, 1'b0, 20'h00003, 16'h1111, 1'b1, lo, we_lo, oe_lo, dqv);
    check("b_wr_ready_lo", lo, 2);
    check("b_wr_we_lo", we_lo, 1);
    check("b_wr_dq_cycles", dqv, 2);
    check("b_wr_stored", {16'd0, mem_b[3]}, 32'h00001111);
    check("b_wr_other", {16'd0, mem_b[12]}, 32'd0);
    check("b_wr_adr_kept", {12'd0, adr_b}, 32'h00003);
    do_read(1'b1, 20'h00003, 16'h1111, 1'b1, 1, "b_rd");
    tick();
    check("b_idle_after", {31'd0, bus_b.o_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
